xgriscv_lsu: RTL

XGRISCV_LSU -- requirements
Module: xgriscv_lsu

---
 rtl/xgriscv_lsu.sv | 125 ++++++++++++
 1 files changed

// File: rtl/xgriscv_lsu.sv
// Load/store unit between the MEM stage and a word-only data memory.
// Loads and sw finish in one cycle; sb/sh do a read-modify-write through MERGE.
module xgriscv_lsu #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [ADDR_SIZE-1:0] req_pc,
  output logic                 resp_valid,
  output logic [XLEN-1:0]      resp_rdata,
  output logic                 resp_err,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_a,
  output logic [XLEN-1:0]      dmem_wd,
  output logic [ADDR_SIZE-1:0] dmem_pc,
  input  logic [XLEN-1:0]      dmem_rd
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t                 r_state, w_nstate;
  logic [XLEN-1:0]        r_addr, r_old;
  logic [15:0]            r_wdata;
  logic                   r_half;
  logic [ADDR_SIZE-1:0]   r_pc;
  logic                   r_resp_valid, r_resp_err;
  logic [XLEN-1:0]        r_resp_rdata;

  logic                   w_legal, w_mis, w_err, w_acc, w_sw, w_rmw;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [XLEN-1:0]        w_ld, w_merge;

  always_comb begin
    w_legal = req_we ? (req_funct3 inside {3'd0, 3'd1, 3'd2})
                     : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    w_mis   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_err   = !w_legal || w_mis;
    w_acc   = req_valid && req_ready;
    w_sw    = w_acc && req_we && !w_err && (req_funct3[1:0] == 2'b10);
    w_rmw   = w_acc && req_we && !w_err && !req_funct3[1];
  end

  // Lane extraction from the combinational read word, then extension.
  always_comb begin
    w_byte = dmem_rd[{req_addr[1:0], 3'b000} +: 8];
    w_half = dmem_rd[{req_addr[1], 4'b0000} +: 16];
    case (req_funct3)
      3'd0:    w_ld = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'd1:    w_ld = {{(XLEN-16){w_half[15]}}, w_half};
      3'd2:    w_ld = dmem_rd;
      3'd4:    w_ld = {{(XLEN-8){1'b0}}, w_byte};
      3'd5:    w_ld = {{(XLEN-16){1'b0}}, w_half};
      default: w_ld = '0;
    endcase
  end

  always_comb begin
    w_merge = r_old;
    if (r_half) w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata;
    else        w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
  end

  always_comb begin
    w_nstate  = r_state;
    req_ready = 1'b0;
    dmem_a    = {req_addr[XLEN-1:2], 2'b00};
    dmem_wd   = req_wdata;
    dmem_pc   = req_pc;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (w_rmw) w_nstate = MERGE;
      end
      MERGE: begin
        dmem_a   = {r_addr[XLEN-1:2], 2'b00};
        dmem_wd  = w_merge;
        dmem_pc  = r_pc;
        w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
    // Gating on rstn keeps a reset that lands mid-RMW from writing.
    dmem_we = rstn && ((r_state == MERGE) || w_sw);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_old        <= '0;
      r_wdata      <= '0;
      r_half       <= 1'b0;
      r_pc         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_nstate;
      r_resp_valid <= (w_acc && !w_rmw) || (r_state == MERGE);
      r_resp_err   <= w_acc && w_err;
      r_resp_rdata <= (w_acc && !req_we && !w_err) ? w_ld : '0;
      if (w_rmw) begin
        r_addr  <= req_addr;
        r_old   <= dmem_rd;
        r_wdata <= req_wdata[15:0];
        r_half  <= req_funct3[0];
        r_pc    <= req_pc;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule
